// File: rtl/salidas_pkg.sv
// Shared types and seven-segment constants for the output controller
// (FSM states, digit/dash/blank segment codes, display limit).
package salidas_pkg;

  typedef enum logic [1:0] {
    REPOSO,
    CONVERTIR,
    ACTUALIZAR
  } estado_t;

  localparam int unsigned MAX_DISPLAY = 9999;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0      = 7'b1000000;
  localparam logic [6:0] SEG_1      = 7'b1111001;
  localparam logic [6:0] SEG_2      = 7'b0100100;
  localparam logic [6:0] SEG_3      = 7'b0110000;
  localparam logic [6:0] SEG_4      = 7'b0011001;
  localparam logic [6:0] SEG_5      = 7'b0010010;
  localparam logic [6:0] SEG_6      = 7'b0000010;
  localparam logic [6:0] SEG_7      = 7'b1111000;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0010000;
  localparam logic [6:0] SEG_GUION  = 7'b0111111;
  localparam logic [6:0] SEG_BLANCO = 7'b1111111;

  function automatic logic [6:0] seg_de_bcd(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANCO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/controlador_salidas_if.sv
// Load/status/display bundle between the datapath side and the output controller.
interface controlador_salidas_if;
  logic [13:0] valor;
  logic        cargar;
  logic        ocupado;
  logic        desborde;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (output valor, cargar, input ocupado, desborde, an, seg);
  modport slave  (input valor, cargar, output ocupado, desborde, an, seg);
endinterface

// File: rtl/bin_a_bcd.sv
// Sequential double-dabble: one input bit per cycle, MSB first, 16-bit BCD result.
module bin_a_bcd #(
  parameter int unsigned ANCHO = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ANCHO-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int unsigned CW = $clog2(ANCHO);

  logic [ANCHO-1:0] sh;
  logic [15:0]      acc;
  logic [15:0]      ajust;
  logic [CW-1:0]    cnt;

  // done flags the final shift happening on the coming edge, so the caller
  // can read bcd from the following cycle on
  assign done = busy && (cnt == CW'(ANCHO - 1));
  assign bcd  = acc;

  always_comb begin
    ajust = acc;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) ajust[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      sh   <= '0;
    end else if (start) begin
      sh   <= bin;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= {ajust[14:0], sh[ANCHO-1]};
      sh  <= sh << 1;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/controlador_salidas.sv
// Binary-to-4-digit multiplexed seven-segment driver with overflow dashes.
// Optional CEROS_IZQ_BLANK_EN blanks leading zeros (units digit always shown).
module controlador_salidas
  import salidas_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  controlador_salidas_if.slave  bus
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);

  estado_t      estado;
  logic         ocupado;
  logic         desborde;
  logic [13:0]  captura;
  logic [3:0]   disp [4];
  logic         inicio;
  logic         conv_busy;
  logic         conv_done;
  logic [15:0]  conv_bcd;

  logic [RW-1:0] cnt_ref;
  logic [1:0]    idx;
  logic [1:0]    idx_sig;
  logic          terminal;
  logic [3:0]    blanco;
  logic [6:0]    seg_sel;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  assign inicio       = (estado == REPOSO) && bus.cargar;
  assign bus.ocupado  = ocupado;
  assign bus.desborde = desborde;
  assign bus.an       = an_q;
  assign bus.seg      = seg_q;

  bin_a_bcd #(.ANCHO(14)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (inicio),
    .bin   (bus.valor),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= REPOSO;
      ocupado  <= 1'b0;
      desborde <= 1'b0;
      captura  <= '0;
      for (int unsigned i = 0; i < 4; i++) disp[i] <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          if (bus.cargar) begin
            captura <= bus.valor;
            ocupado <= 1'b1;
            estado  <= CONVERTIR;
          end
        end
        CONVERTIR: begin
          if (conv_done || !conv_busy) estado <= ACTUALIZAR;
        end
        ACTUALIZAR: begin
          for (int unsigned i = 0; i < 4; i++) disp[i] <= conv_bcd[4*i +: 4];
          desborde <= (captura > 14'(MAX_DISPLAY));
          ocupado  <= 1'b0;
          estado   <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

  always_comb begin
    terminal = (cnt_ref == RW'(REFRESH_DIV - 1));
    idx_sig  = terminal ? idx + 2'd1 : idx;
  end

`ifdef CEROS_IZQ_BLANK_EN
  // A digit blanks only when it and every digit above it are zero
  always_comb begin
    blanco    = '0;
    blanco[3] = (disp[3] == 4'd0);
    blanco[2] = blanco[3] && (disp[2] == 4'd0);
    blanco[1] = blanco[2] && (disp[1] == 4'd0);
  end
`else
  assign blanco = '0;
`endif

  always_comb begin
    if (desborde)             seg_sel = SEG_GUION;
    else if (blanco[idx_sig]) seg_sel = SEG_BLANCO;
    else                      seg_sel = seg_de_bcd(disp[idx_sig]);
  end

  // an and seg both follow idx_sig so they switch on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ref <= '0;
      idx     <= '0;
      an_q    <= 4'b1110;
      seg_q   <= SEG_0;
    end else begin
      cnt_ref <= terminal ? '0 : cnt_ref + RW'(1);
      idx     <= idx_sig;
      an_q    <= ~(4'b0001 << idx_sig);
      seg_q   <= seg_sel;
    end
  end

endmodule
